// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the register-file FIFO controller: default geometry
// and the 3-bit state encodings used by the top and its next-state logic.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;
  localparam int FIFO_CW    = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT     = 3'b000;
  localparam state_t ST_NO_OP    = 3'b001;
  localparam state_t ST_WRITE    = 3'b010;
  localparam state_t ST_WR_ERROR = 3'b011;
  localparam state_t ST_READ     = 3'b100;
  localparam state_t ST_RD_ERROR = 3'b101;

  // Occupancy once the transfer owned by the current state has committed.
  function automatic logic [FIFO_CW-1:0] committed_count(
    input state_t             state,
    input logic [FIFO_CW-1:0] count
  );
    logic [FIFO_CW-1:0] result;
    result = count;
    if (state == ST_WRITE) begin
      result = count + FIFO_CW'(1);
    end else if (state == ST_READ) begin
      result = count - FIFO_CW'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state logic for fifo_ctrl. Full/empty are judged on the
// occupancy after the current state commits, so back-to-back transfers never overshoot.
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = FIFO_CW
) (
  input  state_t          state_i,
  input  logic            wr_en_i,
  input  logic            rd_en_i,
  input  logic [CW-1:0]   count_i,
  output state_t          state_d_o,
  output logic [CW-1:0]   count_d_o
);

  logic full_next;
  logic empty_next;

  always_comb begin
    count_d_o = count_i;
    case (state_i)
      ST_WRITE: count_d_o = count_i + CW'(1);
      ST_READ:  count_d_o = count_i - CW'(1);
      default:  count_d_o = count_i;
    endcase
  end

  assign full_next  = (count_d_o == CW'(DEPTH));
  assign empty_next = (count_d_o == '0);

  // Every state, INIT included, decodes the request pair the same way.
  always_comb begin
    state_d_o = ST_NO_OP;
    if (wr_en_i && !rd_en_i) begin
      state_d_o = full_next ? ST_WR_ERROR : ST_WRITE;
    end else if (rd_en_i && !wr_en_i) begin
      state_d_o = empty_next ? ST_RD_ERROR : ST_READ;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Control stage for an 8x32 register-file FIFO: drives bank write enables and
// the read-mux select, tracks head/tail/occupancy and reports handshake status.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int CW    = FIFO_CW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] we_onehot,
  output logic [AW-1:0]    rd_sel,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [CW-1:0]    data_count,
  output logic [2:0]       state_dbg
);

  // Handshake: a request sampled at edge N selects the state held during
  // cycle N..N+1; its ack/err and bank enable are valid for exactly that cycle,
  // and the transfer commits (pointer and count move) at edge N+1.

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   count_commit;

  fifo_ctrl_ns #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ns (
    .state_i   (state_q),
    .wr_en_i   (wr_en),
    .rd_en_i   (rd_en),
    .count_i   (count_q),
    .state_d_o (state_d),
    .count_d_o (count_commit)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_commit;
    if (state_q == ST_WRITE) begin
      tail_d = tail_q + AW'(1);
    end
    if (state_q == ST_READ) begin
      head_d = head_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Moore decode straight off the state register, so an async reset during
  // a WRITE cycle removes the bank enable without waiting for a clock.
  always_comb begin
    we_onehot = '0;
    if (state_q == ST_WRITE) begin
      we_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << tail_q;
    end
  end

  assign rd_sel     = head_q;
  assign wr_ack     = (state_q == ST_WRITE);
  assign wr_err     = (state_q == ST_WR_ERROR);
  assign rd_ack     = (state_q == ST_READ);
  assign rd_err     = (state_q == ST_RD_ERROR);
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign data_count = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl with hand-written reset corner cases.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] we_onehot;
  logic [2:0] rd_sel;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;
  logic [3:0] data_count;
  logic [2:0] state_dbg;

  fifo_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we_onehot  (we_onehot),
    .rd_sel     (rd_sel),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog expired");
  end

  // handshake code {wr_ack, wr_err, rd_ack, rd_err}
  localparam logic [3:0] HS_NONE = 4'b0000;
  localparam logic [3:0] HS_WACK = 4'b1000;
  localparam logic [3:0] HS_WERR = 4'b0100;
  localparam logic [3:0] HS_RACK = 4'b0010;
  localparam logic [3:0] HS_RERR = 4'b0001;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] we;
    logic [2:0] sel;
    logic       full;
    logic       empty;
    logic [3:0] hs;
    logic [3:0] cnt;
  } vec_t;

  vec_t vec_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add_vec(input logic wr, input logic rd, input logic [7:0] we,
                                  input logic [2:0] sel, input logic [3:0] hs,
                                  input logic [3:0] cnt);
    vec_t v;
    v.wr    = wr;
    v.rd    = rd;
    v.we    = we;
    v.sel   = sel;
    v.hs    = hs;
    v.cnt   = cnt;
    v.full  = (cnt == 4'd8);
    v.empty = (cnt == 4'd0);
    vec_q.push_back(v);
  endfunction

  // scoreboard compare over {we, sel, full, empty, hs, cnt}
  task automatic check(input string name, input logic [7:0] exp_we, input logic [2:0] exp_sel,
                       input logic exp_full, input logic exp_empty, input logic [3:0] exp_hs,
                       input logic [3:0] exp_cnt);
    logic [20:0] act;
    logic [20:0] exp;
    act = {we_onehot, rd_sel, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count};
    exp = {exp_we, exp_sel, exp_full, exp_empty, exp_hs, exp_cnt};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%h sel=%0d full=%b empty=%b hs=%b cnt=%0d, required we=%h sel=%0d full=%b empty=%b hs=%b cnt=%0d",
               name, act[20:13], act[12:10], act[9], act[8], act[7:4], act[3:0],
               exp_we, exp_sel, exp_full, exp_empty, exp_hs, exp_cnt);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] exp_state);
    n_vec++;
    if (state_dbg !== exp_state) begin
      n_fail++;
      $display("FAIL %s: got state=%b, required state=%b", name, state_dbg, exp_state);
    end
  endtask

  // driver: inputs change at the falling edge, outputs sampled at the next falling edge
  task automatic step(input logic wr, input logic rd);
    wr_en = wr;
    rd_en = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    // idle: pointers at 0, empty
    for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b0, 8'h00, 3'd0, HS_NONE, 4'd0);
    // fill 8: enable walks up from entry 0, count is pre-commit value
    for (int k = 0; k < 8; k++) add_vec(1'b1, 1'b0, 8'(1 << k), 3'd0, HS_WACK, 4'(k));
    // overflow
    add_vec(1'b1, 1'b0, 8'h00, 3'd0, HS_WERR, 4'd8);
    // drain 8
    for (int j = 0; j < 8; j++) add_vec(1'b0, 1'b1, 8'h00, 3'(j), HS_RACK, 4'(8 - j));
    // underflow
    add_vec(1'b0, 1'b1, 8'h00, 3'd0, HS_RERR, 4'd0);
    // write 5, read 5
    for (int k = 0; k < 5; k++) add_vec(1'b1, 1'b0, 8'(1 << k), 3'd0, HS_WACK, 4'(k));
    for (int j = 0; j < 5; j++) add_vec(1'b0, 1'b1, 8'h00, 3'(j), HS_RACK, 4'(5 - j));
    // write 6 across the wrap: 0x20,0x40,0x80,0x01,0x02,0x04
    add_vec(1'b1, 1'b0, 8'h20, 3'd5, HS_WACK, 4'd0);
    add_vec(1'b1, 1'b0, 8'h40, 3'd5, HS_WACK, 4'd1);
    add_vec(1'b1, 1'b0, 8'h80, 3'd5, HS_WACK, 4'd2);
    add_vec(1'b1, 1'b0, 8'h01, 3'd5, HS_WACK, 4'd3);
    add_vec(1'b1, 1'b0, 8'h02, 3'd5, HS_WACK, 4'd4);
    add_vec(1'b1, 1'b0, 8'h04, 3'd5, HS_WACK, 4'd5);
    add_vec(1'b0, 1'b0, 8'h00, 3'd5, HS_NONE, 4'd6);
    // read 3 (head wraps 5,6,7 -> 0) down to count 3
    add_vec(1'b0, 1'b1, 8'h00, 3'd5, HS_RACK, 4'd6);
    add_vec(1'b0, 1'b1, 8'h00, 3'd6, HS_RACK, 4'd5);
    add_vec(1'b0, 1'b1, 8'h00, 3'd7, HS_RACK, 4'd4);
    add_vec(1'b0, 1'b0, 8'h00, 3'd0, HS_NONE, 4'd3);
    // simultaneous requests are ignored
    add_vec(1'b1, 1'b1, 8'h00, 3'd0, HS_NONE, 4'd3);
    add_vec(1'b1, 1'b1, 8'h00, 3'd0, HS_NONE, 4'd3);

    // reset state
    repeat (2) @(negedge clk);
    check("reset_asserted", 8'h00, 3'd0, 1'b0, 1'b1, HS_NONE, 4'd0);
    check_state("reset_state_init", 3'b000);
    reset_n = 1'b1;
    #1;
    check("reset_released", 8'h00, 3'd0, 1'b0, 1'b1, HS_NONE, 4'd0);

    foreach (vec_q[i]) begin
      string nm;
      step(vec_q[i].wr, vec_q[i].rd);
      nm = $sformatf("vec%0d", i);
      check(nm, vec_q[i].we, vec_q[i].sel, vec_q[i].full, vec_q[i].empty, vec_q[i].hs, vec_q[i].cnt);
    end

    // write with tail=3, count=3, then async reset inside the WRITE cycle
    step(1'b1, 1'b0);
    check("write_before_reset", 8'h08, 3'd0, 1'b0, 1'b0, HS_WACK, 4'd3);
    check_state("state_write", 3'b010);
    wr_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_mid_write", 8'h00, 3'd0, 1'b0, 1'b1, HS_NONE, 4'd0);
    check_state("reset_mid_write_state", 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    check("after_reset_idle", 8'h00, 3'd0, 1'b0, 1'b1, HS_NONE, 4'd0);
    step(1'b1, 1'b0);
    check("after_reset_write", 8'h01, 3'd0, 1'b0, 1'b1, HS_WACK, 4'd0);
    step(1'b0, 1'b0);
    check("after_reset_count", 8'h00, 3'd0, 1'b0, 1'b0, HS_NONE, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
